// File: rtl/axi_mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_mem_port_arbiter_if
// Bundles the signals between the AXI read controller, the AXI write
// controller, the single-port SRAM macro and the arbiter that shares it.
//   rd_*      : read-controller request, SRAM pins, grant and read return
//   wr_*      : write-controller request, SRAM pins, grant and read return
//   mem_*     : muxed SRAM pins, plus SRAM read data mem_q_i
// Modports:
//   slave  : arbiter view (takes requests, drives grants and SRAM pins)
//   master : environment view (controllers + SRAM)
// ---------------------------------------------------------------------------
interface axi_mem_port_arbiter_if #(
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 64,
    parameter int BE_WIDTH       = DATA_WIDTH / 8
);
    logic                      rd_valid_i;
    logic                      rd_grant_o;
    logic                      rd_cen_i;
    logic                      rd_wen_i;
    logic [MEM_ADDR_WIDTH-1:0] rd_a_i;
    logic [DATA_WIDTH-1:0]     rd_d_i;
    logic [BE_WIDTH-1:0]       rd_be_i;
    logic [DATA_WIDTH-1:0]     rd_q_o;
    logic                      rd_qvalid_o;

    logic                      wr_valid_i;
    logic                      wr_grant_o;
    logic                      wr_cen_i;
    logic                      wr_wen_i;
    logic [MEM_ADDR_WIDTH-1:0] wr_a_i;
    logic [DATA_WIDTH-1:0]     wr_d_i;
    logic [BE_WIDTH-1:0]       wr_be_i;
    logic [DATA_WIDTH-1:0]     wr_q_o;
    logic                      wr_qvalid_o;

    logic                      mem_cen_o;
    logic                      mem_wen_o;
    logic [MEM_ADDR_WIDTH-1:0] mem_a_o;
    logic [DATA_WIDTH-1:0]     mem_d_o;
    logic [BE_WIDTH-1:0]       mem_be_o;
    logic [DATA_WIDTH-1:0]     mem_q_i;

    modport slave (
        input  rd_valid_i, rd_cen_i, rd_wen_i, rd_a_i, rd_d_i, rd_be_i,
        output rd_grant_o, rd_q_o, rd_qvalid_o,
        input  wr_valid_i, wr_cen_i, wr_wen_i, wr_a_i, wr_d_i, wr_be_i,
        output wr_grant_o, wr_q_o, wr_qvalid_o,
        output mem_cen_o, mem_wen_o, mem_a_o, mem_d_o, mem_be_o,
        input  mem_q_i
    );

    modport master (
        output rd_valid_i, rd_cen_i, rd_wen_i, rd_a_i, rd_d_i, rd_be_i,
        input  rd_grant_o, rd_q_o, rd_qvalid_o,
        output wr_valid_i, wr_cen_i, wr_wen_i, wr_a_i, wr_d_i, wr_be_i,
        input  wr_grant_o, wr_q_o, wr_qvalid_o,
        input  mem_cen_o, mem_wen_o, mem_a_o, mem_d_o, mem_be_o,
        output mem_q_i
    );
endinterface

// File: rtl/axi_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// axi_mem_port_arbiter
// Shares one single-port SRAM between the AXI read-only and write-only
// controllers. Same-cycle grant, work-conserving round-robin with a bounded
// burst hold (MAX_HOLD consecutive grants while the other side waits).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : requests/grants, SRAM pins and read return
//   stat_clr_i, stat_rd_cnt_o, stat_wr_cnt_o : grant statistics, present
//                 only when the ARB_STATS_EN macro is defined
// ---------------------------------------------------------------------------
module axi_mem_port_arbiter #(
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 64,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int MAX_HOLD       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axi_mem_port_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    input  logic                  stat_clr_i,
    output logic [31:0]           stat_rd_cnt_o,
    output logic [31:0]           stat_wr_cnt_o
`endif
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    typedef enum logic {GNT_RD = 1'b0, GNT_WR = 1'b1} gnt_e;

    gnt_e                      last_grant_p1;
    logic [7:0]                hold_cnt_p1;
    logic                      rd_qvld_p1;
    logic                      wr_qvld_p1;

    logic                      rd_win_p0;
    logic                      wr_win_p0;
    logic                      keep_p0;
    gnt_e                      winner_p0;
    logic                      mux_cen_p0;
    logic                      mux_wen_p0;
    logic [MEM_ADDR_WIDTH-1:0] mux_a_p0;
    logic [DATA_WIDTH-1:0]     mux_d_p0;
    logic [BE_WIDTH-1:0]       mux_be_p0;

    // Hold counter never exceeds MAX_HOLD, so it can never wrap.
    function automatic logic [7:0] sat_hold(input logic [7:0] h);
        if (h >= MAX_HOLD_C) return MAX_HOLD_C;
        return h + 8'd1;
    endfunction

    // ---- stage p0: combinational arbitration and SRAM mux ----
    assign keep_p0 = (hold_cnt_p1 != 8'd0) && (hold_cnt_p1 < MAX_HOLD_C);

    always_comb begin
        rd_win_p0 = 1'b0;
        wr_win_p0 = 1'b0;
        if (bus.rd_valid_i && bus.wr_valid_i) begin
            // A hold count of 0 (after reset or an idle cycle) hands the
            // contention to the side that did not win last.
            if (keep_p0) rd_win_p0 = (last_grant_p1 == GNT_RD);
            else         rd_win_p0 = (last_grant_p1 == GNT_WR);
            wr_win_p0 = ~rd_win_p0;
        end else begin
            rd_win_p0 = bus.rd_valid_i;
            wr_win_p0 = bus.wr_valid_i;
        end
    end

    assign winner_p0 = wr_win_p0 ? GNT_WR : GNT_RD;

    always_comb begin
        mux_cen_p0 = 1'b1;
        mux_wen_p0 = 1'b1;
        mux_a_p0   = '0;
        mux_d_p0   = '0;
        mux_be_p0  = '0;
        if (rd_win_p0) begin
            mux_cen_p0 = bus.rd_cen_i;
            mux_wen_p0 = bus.rd_wen_i;
            mux_a_p0   = bus.rd_a_i;
            mux_d_p0   = bus.rd_d_i;
            mux_be_p0  = bus.rd_be_i;
        end else if (wr_win_p0) begin
            mux_cen_p0 = bus.wr_cen_i;
            mux_wen_p0 = bus.wr_wen_i;
            mux_a_p0   = bus.wr_a_i;
            mux_d_p0   = bus.wr_d_i;
            mux_be_p0  = bus.wr_be_i;
        end
    end

    assign bus.rd_grant_o = rd_win_p0;
    assign bus.wr_grant_o = wr_win_p0;
    assign bus.mem_cen_o  = mux_cen_p0;
    assign bus.mem_wen_o  = mux_wen_p0;
    assign bus.mem_a_o    = mux_a_p0;
    assign bus.mem_d_o    = mux_d_p0;
    assign bus.mem_be_o   = mux_be_p0;

    // ---- stage p1: arbitration state and read-return valid ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_p1 <= GNT_WR;
            hold_cnt_p1   <= 8'd0;
            rd_qvld_p1    <= 1'b0;
            wr_qvld_p1    <= 1'b0;
        end else begin
            rd_qvld_p1 <= rd_win_p0 && !bus.rd_cen_i && bus.rd_wen_i;
            wr_qvld_p1 <= wr_win_p0 && !bus.wr_cen_i && bus.wr_wen_i;
            if (rd_win_p0 || wr_win_p0) begin
                if (winner_p0 == last_grant_p1) begin
                    hold_cnt_p1 <= sat_hold(hold_cnt_p1);
                end else begin
                    last_grant_p1 <= winner_p0;
                    hold_cnt_p1   <= 8'd1;
                end
            end else begin
                hold_cnt_p1 <= 8'd0;
            end
        end
    end

    assign bus.rd_q_o      = bus.mem_q_i;
    assign bus.wr_q_o      = bus.mem_q_i;
    assign bus.rd_qvalid_o = rd_qvld_p1;
    assign bus.wr_qvalid_o = wr_qvld_p1;

`ifdef ARB_STATS_EN
    logic [31:0] rd_cnt_p1;
    logic [31:0] wr_cnt_p1;

    function automatic logic [31:0] sat_cnt(input logic [31:0] c);
        if (c == 32'hFFFF_FFFF) return c;
        return c + 32'd1;
    endfunction

    // ---- stage p1: grant statistics ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_p1 <= 32'd0;
            wr_cnt_p1 <= 32'd0;
        end else if (stat_clr_i) begin
            rd_cnt_p1 <= 32'd0;
            wr_cnt_p1 <= 32'd0;
        end else begin
            if (rd_win_p0) rd_cnt_p1 <= sat_cnt(rd_cnt_p1);
            if (wr_win_p0) wr_cnt_p1 <= sat_cnt(wr_cnt_p1);
        end
    end

    assign stat_rd_cnt_o = rd_cnt_p1;
    assign stat_wr_cnt_o = wr_cnt_p1;
`endif

endmodule

// File: tb/tb_axi_mem_port_arbiter.sv
module tb_axi_mem_port_arbiter;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int BW = DW / 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    axi_mem_port_arbiter_if #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus4 ();
    axi_mem_port_arbiter_if #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus1 ();

`ifdef ARB_STATS_EN
    logic        stat_clr4;
    logic [31:0] stat_rd4, stat_wr4;
    logic        stat_clr1;
    logic [31:0] stat_rd1, stat_wr1;
`endif

    axi_mem_port_arbiter #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_HOLD(4)) dut4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus4)
`ifdef ARB_STATS_EN
        ,
        .stat_clr_i    (stat_clr4),
        .stat_rd_cnt_o (stat_rd4),
        .stat_wr_cnt_o (stat_wr4)
`endif
    );

    axi_mem_port_arbiter #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_HOLD(1)) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus1)
`ifdef ARB_STATS_EN
        ,
        .stat_clr_i    (stat_clr1),
        .stat_rd_cnt_o (stat_rd1),
        .stat_wr_cnt_o (stat_wr1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle4();
        bus4.rd_valid_i = 1'b0; bus4.rd_cen_i = 1'b1; bus4.rd_wen_i = 1'b1;
        bus4.rd_a_i = '0; bus4.rd_d_i = '0; bus4.rd_be_i = '0;
        bus4.wr_valid_i = 1'b0; bus4.wr_cen_i = 1'b1; bus4.wr_wen_i = 1'b1;
        bus4.wr_a_i = '0; bus4.wr_d_i = '0; bus4.wr_be_i = '0;
        bus4.mem_q_i = '0;
    endtask

    task automatic idle1();
        bus1.rd_valid_i = 1'b0; bus1.rd_cen_i = 1'b1; bus1.rd_wen_i = 1'b1;
        bus1.rd_a_i = '0; bus1.rd_d_i = '0; bus1.rd_be_i = '0;
        bus1.wr_valid_i = 1'b0; bus1.wr_cen_i = 1'b1; bus1.wr_wen_i = 1'b1;
        bus1.wr_a_i = '0; bus1.wr_d_i = '0; bus1.wr_be_i = '0;
        bus1.mem_q_i = '0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // Read request on rd side, write request on wr side, distinct addresses.
    task automatic load_both4();
        bus4.rd_cen_i = 1'b0; bus4.rd_wen_i = 1'b1; bus4.rd_a_i = 13'h020;
        bus4.rd_be_i = 8'hFF; bus4.rd_d_i = 64'h0;
        bus4.wr_cen_i = 1'b0; bus4.wr_wen_i = 1'b0; bus4.wr_a_i = 13'h030;
        bus4.wr_be_i = 8'h0F; bus4.wr_d_i = 64'hCAFE_0000_0000_BEEF;
    endtask

    initial begin
        logic exp_rd10 [10];
        logic exp_late [3];
        logic exp_alt  [4];
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle4();
        idle1();
`ifdef ARB_STATS_EN
        stat_clr4 = 1'b0;
        stat_clr1 = 1'b0;
`endif
        exp_rd10 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state
        #2;
        chk("rst_rd_qvalid", 64'(bus4.rd_qvalid_o), 64'd0);
        chk("rst_wr_qvalid", 64'(bus4.wr_qvalid_o), 64'd0);
        chk("rst_rd_grant", 64'(bus4.rd_grant_o), 64'd0);
        chk("rst_wr_grant", 64'(bus4.wr_grant_o), 64'd0);
        chk("rst_mem_cen", 64'(bus4.mem_cen_o), 64'd1);
`ifdef ARB_STATS_EN
        chk("rst_stat_rd", 64'(stat_rd4), 64'd0);
        chk("rst_stat_wr", 64'(stat_wr4), 64'd0);
`endif
        next_cycle();
        rst_n = 1'b1;

        // Single read request
        next_cycle();
        bus4.rd_valid_i = 1'b1; bus4.rd_cen_i = 1'b0; bus4.rd_wen_i = 1'b1;
        bus4.rd_a_i = 13'h010; bus4.rd_be_i = 8'hFF; bus4.rd_d_i = 64'h1234;
        #1;
        chk("rd1_grant", 64'(bus4.rd_grant_o), 64'd1);
        chk("rd1_wr_grant", 64'(bus4.wr_grant_o), 64'd0);
        chk("rd1_mem_a", 64'(bus4.mem_a_o), 64'h010);
        chk("rd1_mem_cen", 64'(bus4.mem_cen_o), 64'd0);
        chk("rd1_mem_wen", 64'(bus4.mem_wen_o), 64'd1);
        chk("rd1_mem_be", 64'(bus4.mem_be_o), 64'hFF);
        chk("rd1_mem_d", 64'(bus4.mem_d_o), 64'h1234);
        next_cycle();
        idle4();
        bus4.mem_q_i = 64'hDEAD_BEEF_0000_0001;
        #1;
        chk("rd1_qvalid", 64'(bus4.rd_qvalid_o), 64'd1);
        chk("rd1_q", bus4.rd_q_o, 64'hDEAD_BEEF_0000_0001);
        chk("rd1_wq", bus4.wr_q_o, 64'hDEAD_BEEF_0000_0001);
        chk("rd1_wr_qvalid", 64'(bus4.wr_qvalid_o), 64'd0);

        // Idle: default SRAM pins even with non-zero request fields
        next_cycle();
        bus4.rd_cen_i = 1'b0; bus4.rd_a_i = 13'h055; bus4.rd_be_i = 8'hAA;
        #1;
        chk("idle_rd_qvalid", 64'(bus4.rd_qvalid_o), 64'd0);
        chk("idle_grants", {62'd0, bus4.rd_grant_o, bus4.wr_grant_o}, 64'd0);
        chk("idle_mem_cen", 64'(bus4.mem_cen_o), 64'd1);
        chk("idle_mem_wen", 64'(bus4.mem_wen_o), 64'd1);
        chk("idle_mem_a", 64'(bus4.mem_a_o), 64'd0);
        chk("idle_mem_be", 64'(bus4.mem_be_o), 64'd0);
        chk("idle_mem_d", bus4.mem_d_o, 64'd0);

        // Continuous contention, MAX_HOLD=4, starting from reset
        next_cycle();
        idle4();
        pulse_reset();
        load_both4();
        bus4.rd_valid_i = 1'b1;
        bus4.wr_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next_cycle();
            #1;
            chk($sformatf("burst%0d_rd_grant", i), 64'(bus4.rd_grant_o), 64'(exp_rd10[i]));
            chk($sformatf("burst%0d_wr_grant", i), 64'(bus4.wr_grant_o), 64'(!exp_rd10[i]));
            chk($sformatf("burst%0d_mem_a", i), 64'(bus4.mem_a_o), exp_rd10[i] ? 64'h020 : 64'h030);
            chk($sformatf("burst%0d_mem_wen", i), 64'(bus4.mem_wen_o), 64'(exp_rd10[i]));
            chk($sformatf("burst%0d_wr_qvalid", i), 64'(bus4.wr_qvalid_o), 64'd0);
            chk($sformatf("burst%0d_rd_qvalid", i), 64'(bus4.rd_qvalid_o),
                (i > 0 && exp_rd10[i-1]) ? 64'd1 : 64'd0);
        end

        // Async reset while a read return is pending
        next_cycle();
        bus4.rd_valid_i = 1'b0;
        bus4.wr_valid_i = 1'b0;
        #1;
        chk("arst_pre_qvalid", 64'(bus4.rd_qvalid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_qvalid", 64'(bus4.rd_qvalid_o), 64'd0);
        #1;
        rst_n = 1'b1;

        // WR alone for 10 cycles, then RD joins
        next_cycle();
        pulse_reset();
        load_both4();
        bus4.wr_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next_cycle();
            #1;
            chk($sformatf("wralone%0d_wr_grant", i), 64'(bus4.wr_grant_o), 64'd1);
        end
        next_cycle();
        bus4.rd_valid_i = 1'b1;
        #1;
        chk("wrsat_rd_grant", 64'(bus4.rd_grant_o), 64'd1);
        chk("wrsat_wr_grant", 64'(bus4.wr_grant_o), 64'd0);

        // WR alone for 2 cycles, then RD joins: WR holds until 4 grants
        next_cycle();
        bus4.rd_valid_i = 1'b0;
        bus4.wr_valid_i = 1'b0;
        pulse_reset();
        bus4.wr_valid_i = 1'b1;
        next_cycle();
        next_cycle();
        bus4.rd_valid_i = 1'b1;
        exp_late = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            #1;
            chk($sformatf("wrhold%0d_rd_grant", i), 64'(bus4.rd_grant_o), 64'(exp_late[i]));
            chk($sformatf("wrhold%0d_wr_grant", i), 64'(bus4.wr_grant_o), 64'(!exp_late[i]));
        end

        // MAX_HOLD=1: strict alternation, idle after WR, then RD first
        next_cycle();
        idle4();
        pulse_reset();
        bus1.rd_valid_i = 1'b1; bus1.rd_cen_i = 1'b0; bus1.rd_wen_i = 1'b1; bus1.rd_a_i = 13'h101;
        bus1.wr_valid_i = 1'b1; bus1.wr_cen_i = 1'b0; bus1.wr_wen_i = 1'b0; bus1.wr_a_i = 13'h202;
        exp_alt = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            #1;
            chk($sformatf("alt%0d_rd_grant", i), 64'(bus1.rd_grant_o), 64'(exp_alt[i]));
            chk($sformatf("alt%0d_wr_grant", i), 64'(bus1.wr_grant_o), 64'(!exp_alt[i]));
            chk($sformatf("alt%0d_mem_a", i), 64'(bus1.mem_a_o), exp_alt[i] ? 64'h101 : 64'h202);
        end
        next_cycle();
        bus1.rd_valid_i = 1'b0;
        bus1.wr_valid_i = 1'b0;
        #1;
        chk("alt_idle_grants", {62'd0, bus1.rd_grant_o, bus1.wr_grant_o}, 64'd0);
        next_cycle();
        bus1.rd_valid_i = 1'b1;
        bus1.wr_valid_i = 1'b1;
        #1;
        chk("alt_after_idle_rd", 64'(bus1.rd_grant_o), 64'd1);
        chk("alt_after_idle_wr", 64'(bus1.wr_grant_o), 64'd0);
        next_cycle();
        idle1();

`ifdef ARB_STATS_EN
        // Statistics: 5 RD grants, 3 WR grants, then clear alongside a grant
        pulse_reset();
        load_both4();
        bus4.rd_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) next_cycle();
        bus4.rd_valid_i = 1'b0;
        bus4.wr_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) next_cycle();
        bus4.wr_valid_i = 1'b0;
        #1;
        chk("stat_rd_cnt", 64'(stat_rd4), 64'd5);
        chk("stat_wr_cnt", 64'(stat_wr4), 64'd3);
        next_cycle();
        bus4.rd_valid_i = 1'b1;
        stat_clr4 = 1'b1;
        next_cycle();
        bus4.rd_valid_i = 1'b0;
        stat_clr4 = 1'b0;
        #1;
        chk("stat_clr_rd", 64'(stat_rd4), 64'd0);
        chk("stat_clr_wr", 64'(stat_wr4), 64'd0);
        chk("stat_dut1_rd", 64'(stat_rd1), 64'd0);
        chk("stat_dut1_wr", 64'(stat_wr1), 64'd0);
`endif

        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_mem_port_arbiter.md
Name: axi_mem_port_arbiter

Overview:
- Shares one single-port SRAM macro between the AXI read-only controller and the AXI write-only controller of the memory-interface slave.
- Takes the per-requester valid/memory-port signals and returns a same-cycle grant, which each controller consumes as grant_i.
- Muxes the winner onto the SRAM pins and flags the read data returned one cycle later.
- Uses work-conserving round-robin with a bounded burst-hold, so bursts stay efficient without starving the other side.

Parameters:
- MEM_ADDR_WIDTH, 13, SRAM word-address width.
- DATA_WIDTH, 64, SRAM data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- MAX_HOLD, 4, max consecutive grants to one requester while the other is waiting. Legal range is 1..255; 1 means strict alternation.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- rd_valid_i  in  1  read controller requests an SRAM cycle
- rd_grant_o  out  1  read controller owns the SRAM this cycle
- rd_cen_i  in  1  read-side chip enable, active low
- rd_wen_i  in  1  read-side write enable, active low
- rd_a_i  in  MEM_ADDR_WIDTH  read-side address
- rd_d_i  in  DATA_WIDTH  read-side write data
- rd_be_i  in  BE_WIDTH  read-side byte enables
- rd_q_o  out  DATA_WIDTH  SRAM read data to the read controller
- rd_qvalid_o  out  1  rd_q_o holds data from a granted read issued last cycle
- wr_valid_i, wr_grant_o, wr_cen_i, wr_wen_i, wr_a_i, wr_d_i, wr_be_i, wr_q_o, wr_qvalid_o  (same directions, widths and meanings, for the write controller)
- mem_cen_o  out  1  SRAM chip enable, active low
- mem_wen_o  out  1  SRAM write enable, active low
- mem_a_o  out  MEM_ADDR_WIDTH  SRAM address
- mem_d_o  out  DATA_WIDTH  SRAM write data
- mem_be_o  out  BE_WIDTH  SRAM byte enables
- mem_q_i  in  DATA_WIDTH  SRAM read data, valid one cycle after an access
- stat_clr_i  in  1  synchronous clear of the statistics counters (ARB_STATS_EN only)
- stat_rd_cnt_o  out  32  read-side grant count (ARB_STATS_EN only)
- stat_wr_cnt_o  out  32  write-side grant count (ARB_STATS_EN only)

Behaviour:
- Reset values: last_grant=WR, hold_cnt=0, rd_qvalid_o=0, wr_qvalid_o=0, stat counters=0.
- During reset, all grants are combinationally 0 only when both valid_i inputs are 0. Grants are purely combinational from the valid_i inputs and registered state, with no extra latency.
- Arbitration is evaluated every cycle:
  - Only one valid_i high: grant that requester.
  - Neither high: no grant.
  - Both high: grant last_grant if hold_cnt != 0 and hold_cnt < MAX_HOLD; otherwise grant the other requester.
  - Consequence: after reset, the first contention goes to RD.
- At most one grant is ever high. A grant is never high without its valid_i.
- State update on a granted cycle:
  - Winner == last_grant: hold_cnt = min(hold_cnt+1, MAX_HOLD).
  - Winner differs: last_grant = winner, hold_cnt = 1.
- State update on a no-grant cycle: hold_cnt = 0, last_grant unchanged, so the next contention alternates.
- hold_cnt is 8 bits wide and saturates; it never wraps.
- SRAM mux:
  - When X is granted, mem_* outputs are the X_* inputs unchanged (cen, wen, a, d, be).
  - When nothing is granted: mem_cen_o=1, mem_wen_o=1, mem_a_o=0, mem_d_o=0, mem_be_o=0.
- Read return:
  - rd_q_o = wr_q_o = mem_q_i, combinational.
  - X_qvalid_o is set the cycle after X was granted with X_cen_i=0 and X_wen_i=1, and is 0 otherwise.
  - Writes (wen=0) and granted cycles with cen=1 produce no qvalid.
- A requester that drops valid_i mid-burst simply loses ownership; no lock is held.
- An async reset mid-burst drops any pending qvalid; the controllers are reset together with the arbiter.

Optional Feature:
ARB_STATS_EN
- Defined: adds stat_clr_i, stat_rd_cnt_o and stat_wr_cnt_o.
  - Each counter increments by 1 on every cycle its requester is granted.
  - Counters saturate at 32'hFFFF_FFFF.
  - stat_clr_i forces both counters to 0 on the next edge and takes priority over increment.
- Not defined: these ports and registers are absent, and arbitration is identical.

Test Plan:
- Reset, then rd_valid_i=1 only with rd_cen=0, rd_wen=1, rd_a=0x010 -> same cycle rd_grant_o=1, mem_a_o=0x010, mem_cen_o=0. Next cycle rd_qvalid_o=1 and rd_q_o=mem_q_i.
- Both valid continuously with MAX_HOLD=4 after reset -> grant sequence RD,RD,RD,RD,WR,WR,WR,WR,RD... No cycle without a grant; wr_qvalid_o stays 0 for writes (wr_wen=0).
- MAX_HOLD=1, both valid -> strict alternation RD,WR,RD,WR. Idle cycle after a WR grant, then both valid -> RD granted.
- WR alone for 10 cycles (hold_cnt saturates at 4), then RD joins -> WR keeps its grant only while hold_cnt<4, so RD wins on the first contention cycle; no wrap of hold_cnt.
- Neither valid -> mem_cen_o=1, mem_wen_o=1, mem_a_o=0, mem_be_o=0, both grants 0. Assert rst_n=0 mid-read -> rd_qvalid_o=0 immediately.
- ARB_STATS_EN: 5 RD grants then 3 WR grants -> stat_rd_cnt_o=5, stat_wr_cnt_o=3. stat_clr_i together with a grant -> both counters read 0 next cycle.
